// File: rtl/btn_mem_pkg.sv
// btn_mem_pkg: shared FSM state type and fixed-mode address helper for btn_mem_writer.
package btn_mem_pkg;

    typedef enum logic {IDLE, WRITE} state_t;

    function automatic logic [63:0] fixed_addr(input logic [63:0] base, input logic [63:0] stride,
                                               input int unsigned idx);
        return base + 64'(idx) * stride;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, debounce counter and one-cycle press pulse for one
// active-low button.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_n,
    output logic o_press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]       r_sync;
    logic             r_db;
    logic             r_db_d;
    logic [CNT_W-1:0] r_cnt;

    // Counter tracks consecutive cycles the synced level differs from the accepted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
            r_db   <= 1'b1;
            r_db_d <= 1'b1;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_btn_n};
            r_db_d <= r_db;
            if (r_sync[1] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                r_db  <= r_sync[1];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_db_d & ~r_db;

endmodule

// File: rtl/btn_mem_writer.sv
// btn_mem_writer: turns debounced button presses into single req/ack memory writes,
// with fixed per-button or sequential log addressing.
module btn_mem_writer
    import btn_mem_pkg::*;
#(
    parameter int          N_BTN        = 3,
    parameter int          ADDR_W       = 32,
    parameter int          DATA_W       = 32,
    parameter int          DEBOUNCE_CYC = 4,
    parameter int unsigned BASE_ADDR    = 1,
    parameter int unsigned ADDR_STRIDE  = 0,
    parameter int          LOG_MODE     = 0,
    parameter int          LOG_DEPTH    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_BTN-1:0]  btn,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic              mem_ack,
    output logic              busy,
    output logic              drop
);
    localparam int IDX_W = $clog2(N_BTN + 1);
    localparam int PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

    logic [N_BTN-1:0]  w_press;
    logic [N_BTN-1:0]  w_drop_mask;
    logic [N_BTN-1:0]  w_clr;
    logic [N_BTN-1:0]  r_pending;
    logic [IDX_W-1:0]  w_sel;
    logic [IDX_W-1:0]  r_cur;
    logic [PTR_W-1:0]  r_ptr;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_drop;
    logic              w_load;
    logic              w_done;
    state_t            r_state;
    state_t            w_state_nxt;

    for (genvar i = 0; i < N_BTN; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_btn_n (btn[i]),
            .o_press (w_press[i])
        );
    end

    always_comb begin
        w_sel = '0;
        for (int k = N_BTN - 1; k >= 0; k--)
            if (r_pending[k]) w_sel = IDX_W'(k);
    end

    always_comb begin
        w_load      = (r_state == IDLE) && (|r_pending);
        w_done      = (r_state == WRITE) && mem_ack;
        w_state_nxt = w_load ? WRITE : w_done ? IDLE : r_state;
        w_clr       = w_load ? (N_BTN'(1) << w_sel) : '0;
        // The button being written counts as pending so a re-press during its write is dropped.
        w_drop_mask = r_pending | ((r_state == WRITE) ? (N_BTN'(1) << r_cur) : '0);
        w_addr      = (LOG_MODE != 0) ? ADDR_W'(64'(BASE_ADDR) + 64'(r_ptr))
                                      : ADDR_W'(fixed_addr(64'(BASE_ADDR), 64'(ADDR_STRIDE), 32'(w_sel)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_drop    <= 1'b0;
            r_cur     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_ptr     <= '0;
        end else begin
            r_pending <= (r_pending | (w_press & ~w_drop_mask)) & ~w_clr;
            r_drop    <= |(w_press & w_drop_mask);
            if (w_load) begin
                r_cur  <= w_sel;
                r_addr <= w_addr;
                r_data <= DATA_W'(w_sel) + DATA_W'(1);
            end
            if (w_done && LOG_MODE != 0)
                r_ptr <= (r_ptr == PTR_W'(LOG_DEPTH - 1)) ? '0 : r_ptr + 1'b1;
        end
    end

    assign mem_we   = (r_state == WRITE);
    assign mem_addr = r_addr;
    assign mem_data = r_data;
    assign busy     = mem_we | (|r_pending);
    assign drop     = r_drop;

endmodule

// File: tb/tb_btn_mem_writer.sv
// tb_btn_mem_writer: directed stimulus with an expected-write scoreboard per DUT instance
// (fixed addressing and 4-slot log addressing).
`timescale 1ns/1ps
module tb_btn_mem_writer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  btn_f, btn_l;
    logic        ack_f, ack_l;
    logic        we_f, we_l, busy_f, busy_l, drop_f, drop_l;
    logic [31:0] addr_f, addr_l, data_f, data_l;

    int tests = 0, fails = 0;
    int wr_f = 0, wr_l = 0, we_cyc_f = 0, drops = 0;
    bit ack_tie = 1'b1;
    int ack_dly = 0;
    logic [63:0] q_f[$], q_l[$];

    always #5 clk = ~clk;

    btn_mem_writer u_fix (
        .clk(clk), .rst_n(rst_n), .btn(btn_f), .mem_we(we_f), .mem_addr(addr_f),
        .mem_data(data_f), .mem_ack(ack_f), .busy(busy_f), .drop(drop_f)
    );

    btn_mem_writer #(.LOG_MODE(1), .LOG_DEPTH(4), .BASE_ADDR(8)) u_log (
        .clk(clk), .rst_n(rst_n), .btn(btn_l), .mem_we(we_l), .mem_addr(addr_l),
        .mem_data(data_l), .mem_ack(ack_l), .busy(busy_l), .drop(drop_l)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (drop_f) drops++;
            if (we_f) begin
                we_cyc_f++;
                if (q_f.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write_f: addr %0h data %0h, no write expected", addr_f, data_f);
                end else begin
                    chk("write_f", {addr_f, data_f}, q_f[0]);
                    if (ack_f) begin
                        void'(q_f.pop_front());
                        wr_f++;
                    end
                end
            end
            if (we_l) begin
                if (q_l.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write_l: addr %0h data %0h, no write expected", addr_l, data_l);
                end else begin
                    chk("write_l", {addr_l, data_l}, q_l[0]);
                    if (ack_l) begin
                        void'(q_l.pop_front());
                        wr_l++;
                    end
                end
            end
        end
    end

    initial begin
        int c = 0;
        ack_f = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            c = we_f ? c + 1 : 0;
            ack_f = ack_tie | (we_f && c >= ack_dly);
        end
    end

    task automatic press(input bit lg, input logic [2:0] m, input int hold);
        @(negedge clk);
        if (lg) btn_l &= ~m; else btn_f &= ~m;
        repeat (hold) @(negedge clk);
        if (lg) btn_l |= m; else btn_f |= m;
    endtask

    task automatic drain(input string nm);
        int c = 0;
        repeat (12) @(negedge clk);
        while ((q_f.size() != 0 || q_l.size() != 0 || busy_f || busy_l || we_f || we_l) && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk(nm, 64'(c < 400), 64'd1);
    endtask

    task automatic wait_we(input string nm);
        int c = 0;
        while (!we_f && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk(nm, 64'(we_f), 64'd1);
    endtask

    initial begin
        int w0, d0;
        rst_n = 1'b0;
        btn_f = 3'b111;
        btn_l = 3'b111;
        ack_l = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_we", {63'd0, we_f}, 64'd0);
        chk("rst_addr", 64'(addr_f), 64'd0);
        chk("rst_data", 64'(data_f), 64'd0);
        chk("rst_busy", {62'd0, busy_f, busy_l}, 64'd0);
        chk("rst_drop", {62'd0, drop_f, drop_l}, 64'd0);
        rst_n = 1'b1;

        // Held button with ack tied high: one write, mem_we high for a single cycle.
        w0 = we_cyc_f;
        q_f.push_back({32'd1, 32'd1});
        press(0, 3'b001, 20);
        drain("t1_drain");
        chk("t1_writes", 64'(wr_f), 64'd1);
        chk("t1_we_cycles", 64'(we_cyc_f - w0), 64'd1);

        // Three-cycle glitch is filtered, a longer press is accepted.
        press(0, 3'b010, 3);
        repeat (20) @(negedge clk);
        chk("t2_glitch", 64'(wr_f), 64'd1);
        q_f.push_back({32'd1, 32'd2});
        press(0, 3'b010, 6);
        drain("t2_drain");
        chk("t2_writes", 64'(wr_f), 64'd2);

        // Simultaneous presses with a five-cycle ack: ascending order, busy throughout.
        ack_tie = 1'b0;
        ack_dly = 5;
        q_f.push_back({32'd1, 32'd1});
        q_f.push_back({32'd1, 32'd3});
        @(negedge clk);
        btn_f = 3'b010;
        wait_we("t3_we_rise");
        btn_f = 3'b111;
        repeat (11) begin
            chk("t3_busy", 64'(busy_f), 64'd1);
            @(negedge clk);
        end
        drain("t3_drain");
        chk("t3_writes", 64'(wr_f), 64'd4);
        chk("t3_idle_busy", 64'(busy_f), 64'd0);

        // Re-press of an already pending button during a stalled write drops once.
        ack_dly = 1000;
        d0 = drops;
        q_f.push_back({32'd1, 32'd1});
        q_f.push_back({32'd1, 32'd2});
        press(0, 3'b001, 10);
        wait_we("t4_we_rise");
        press(0, 3'b010, 10);
        repeat (10) @(negedge clk);
        press(0, 3'b010, 10);
        repeat (10) @(negedge clk);
        chk("t4_drop", 64'(drops - d0), 64'd1);
        chk("t4_stalled", 64'(wr_f), 64'd4);
        chk("t4_busy", 64'(busy_f), 64'd1);
        ack_dly = 0;
        drain("t4_drain");
        chk("t4_writes", 64'(wr_f), 64'd6);

        // Log addressing wraps after four slots.
        for (int i = 0; i < 5; i++) begin
            q_l.push_back({32'(8 + (i % 4)), 32'((i % 3) + 1)});
            press(1, 3'(1 << (i % 3)), 10);
            repeat (12) @(negedge clk);
        end
        drain("log_drain");
        chk("log_writes", 64'(wr_l), 64'd5);

        // Asynchronous reset during a stalled write.
        ack_dly = 1000;
        q_f.push_back({32'd1, 32'd1});
        press(0, 3'b001, 10);
        wait_we("t6_we_rise");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q_f.delete();
        #1;
        chk("t6_async_we", 64'(we_f), 64'd0);
        chk("t6_async_busy", 64'(busy_f), 64'd0);
        chk("t6_async_addr", 64'(addr_f), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ack_dly = 0;
        repeat (30) @(negedge clk);
        chk("t6_no_write", 64'(wr_f), 64'd6);
        q_l.push_back({32'd8, 32'd1});
        press(1, 3'b001, 10);
        drain("t6_log_drain");
        chk("t6_log_ptr_reset", 64'(wr_l), 64'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule

// File: doc/btn_mem_writer.md
Name: btn_mem_writer

Overview:
Parametrised, fully synchronous button-to-memory write controller. Each of N_BTN active-low push buttons, once synchronised and debounced, issues exactly one memory write per press: data = button index + 1, to a computed address. Writes use a req/ack handshake towards the memory port. Sits between the board buttons and the RAM write port; replaces the previous combinational button decoder.

Parameters:
N_BTN, 3, number of buttons (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width
DEBOUNCE_CYC, 4, stable cycles required before a level change is accepted (>=1)
BASE_ADDR, 1, address written by button 0 / first log slot
ADDR_STRIDE, 0, per-button address offset in fixed mode
LOG_MODE, 0, 0 = fixed addressing; 1 = sequential log addressing
LOG_DEPTH, 16, number of log slots in LOG_MODE (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn  in  N_BTN  raw buttons, active-low (0 = pressed), asynchronous
mem_we  out  1  write request, held until accepted
mem_addr  out  ADDR_W  write address, stable while mem_we=1
mem_data  out  DATA_W  write data, stable while mem_we=1
mem_ack  in  1  memory accepts write in the cycle mem_we=1 and mem_ack=1
busy  out  1  1 when a write is outstanding or any press is pending
drop  out  1  one-cycle pulse: press lost because that button was already pending

Behaviour:
- Reset (async assert, sync release): mem_we=0, mem_addr=0, mem_data=0, busy=0, drop=0, pending=0, log pointer=0, debounced levels = released, sync flops = released (1).
- Sync: 2-flop synchroniser per button; raw levels never used elsewhere.
- Debounce per button: counter restarts whenever synced level != debounced level; when it reaches DEBOUNCE_CYC-1 consecutive mismatching cycles (i.e. DEBOUNCE_CYC cycles of new level), debounced level updates. Glitch shorter than DEBOUNCE_CYC cycles: no effect.
- Press event: debounced level 1->0 gives one-cycle press[i]. Release generates nothing. Held button: one write only.
- Pending: press[i] sets pending[i]. If pending[i] already set, or button i is the one currently being written, drop pulses 1 cycle; pending unchanged.
- FSM states IDLE, WRITE.
  - IDLE: if any pending, select lowest index i, clear pending[i], load mem_addr/mem_data, mem_we=1 next cycle, go WRITE. Else stay.
  - WRITE: hold mem_we/addr/data. On mem_ack: mem_we=0 next cycle, go IDLE; LOG_MODE pointer advances. Min spacing between writes: 2 cycles (ack cycle + IDLE cycle).
- mem_data = i+1, zero-extended to DATA_W.
- mem_addr: LOG_MODE=0 -> BASE_ADDR + i*ADDR_STRIDE (mod 2^ADDR_W). LOG_MODE=1 -> BASE_ADDR + ptr; ptr wraps LOG_DEPTH-1 -> 0.
- mem_addr/mem_data hold last written values after ack (not cleared).
- Latency: debounced press to mem_we=1 = 2 cycles (pending set, then IDLE load) when idle.
- Simultaneous presses same cycle: all pending; served in ascending index order.
- Press of other buttons during WRITE: queued, no drop.
- busy = (state==WRITE) | (|pending).
- Reset mid-WRITE: mem_we drops immediately (async), request lost, pointer back to 0.
- mem_ack while mem_we=0: ignored.

Decomposition:
- Package btn_mem_pkg: state enum (IDLE, WRITE), function computing fixed-mode address from index.
- Sub-module btn_debounce (one instance per button via generate): synchroniser + debounce counter + press pulse, parameter DEBOUNCE_CYC.
- Top: pending register, priority select, FSM, log pointer.

Test Plan:
- Reset then btn[0]=0 held 20 cycles, mem_ack tied 1 -> exactly one write, addr=1, data=1; mem_we high 1 cycle.
- btn[1] glitch low 3 cycles (DEBOUNCE_CYC=4) -> no write; low 4+ cycles -> one write data=2 addr=1.
- btn[2] and btn[0] pressed same cycle, mem_ack delayed 5 cycles -> writes data=1 then data=3; mem_we/addr/data stable during wait; busy high throughout.
- During stalled write of button 0, press button 1 twice (release in between) -> one drop pulse; button 1 written once after.
- LOG_MODE=1, LOG_DEPTH=4, BASE_ADDR=8: 5 presses -> addresses 8,9,10,11,8.
- Assert rst_n=0 mid-WRITE -> mem_we=0 same cycle without clk edge; after release no write until a new press.
